regincr_pipe: RTL
=================

Name: regincr_pipe

Overview:
- Parametrised, elastic, multi-stage registered incrementer.
- Each of NSTAGES pipeline registers adds INC to the message as it passes through.
- Result: out_msg = in_msg + NSTAGES*INC (mod 2^NBITS).
- Uses val/rdy latency-insensitive handshakes on both sides, so it drops into val/rdy test harnesses and composes with other val/rdy blocks in the design.

Parameters:
- p_nbits, 8, message width in bits (>=1).
- p_nstages, 2, number of pipeline register stages (>=1).
- p_inc, 1, per-stage increment constant; must satisfy 0 <= p_inc < 2^p_nbits.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- in_val  input  1  upstream message valid.
- in_rdy  output  1  block can accept a message this cycle.
- in_msg  input  p_nbits  upstream message.
- out_val  output  1  final-stage message valid.
- out_rdy  input  1  downstream can accept.
- out_msg  output  p_nbits  final-stage message.
- occupancy  output  clog2(p_nstages+1)  number of messages currently held in the pipeline.

Behaviour:
- Reset is synchronous, active-high on clk; clock is clk.
- Reset state:
  - All stage valid bits = 0 and all stage data registers = 0.
  - Therefore out_val = 0, out_msg = 0, occupancy = 0.
  - in_rdy = 1 in the first cycle after reset deasserts.
- Stage model: stage i (0..p_nstages-1) holds val[i] and data[i]. Stage 0 is fed from in_*; the last stage drives out_*.
- Advance condition: stage i may load when !val[i], or when stage i is being drained this cycle (stage i+1 loads from it, or out_rdy for the last stage). The ready chain is combinational from out_rdy back to in_rdy.
- Fire definitions:
  - In fire = in_val && in_rdy.
  - Out fire = out_val && out_rdy.
- Load rule:
  - On load, data[i] <= src + p_inc, truncated to p_nbits (wrap-around), where src is in_msg for stage 0 or data[i-1] otherwise.
  - val[i] <= val of the source.
- Non-loading stage: holds data and val unchanged. A bubble (source not valid) loaded into a stage clears val[i]; data[i] contents are then don't-care.
- Stall stability: while out_val=1 and out_rdy=0, out_msg and out_val must stay stable until out fire.
- Latency and throughput:
  - With out_rdy held at 1, a message accepted at cycle t appears with out_val=1 at cycle t+p_nstages.
  - Full throughput: one message per cycle.
- Bubbles: interior bubbles collapse, because an invalid stage always accepts. With out_rdy=0, the pipeline fills to exactly p_nstages messages, then in_rdy=0.
- Occupancy:
  - +1 on in fire only; -1 on out fire only; unchanged when both or neither.
  - Never exceeds p_nstages and never underflows.
- Simultaneous in fire and out fire when the pipeline is full is legal. It requires all stages to shift and keeps occupancy = p_nstages.
- Reset mid-operation: all in-flight messages are discarded with no out fire. Next cycle, outputs are at their reset values regardless of in_val/out_rdy.
- Arithmetic:
  - Unsigned only.
  - The per-stage add is computed at p_nbits+1 bits; the carry is discarded (or used by the optional feature).
- Line tracing (non-synthesis only) shows in_msg, the per-stage valid/data, and out_msg each cycle. An empty stage prints as blanks.

Optional Feature:
- Macro: REGINCR_PIPE_SAT_EN.
- Defined: each stage saturates. If src + p_inc > 2^p_nbits-1, the stage loads 2^p_nbits-1 (all ones) instead of wrapping. Saturation is sticky through later stages, since all-ones + p_inc saturates again.
- Undefined: modular wrap-around as above; carry discarded.
- Handshake, latency and occupancy are identical in both builds.

Test Plan (default params unless stated: p_nbits=8, p_nstages=2, p_inc=1):
- Single message, in_msg=0x05 at cycle 0, out_rdy=1 -> out_val=1, out_msg=0x07 at cycle 2; occupancy 1,1,0.
- Back-to-back 0x10,0x20,0x30 on consecutive cycles, out_rdy=1 -> outputs 0x12,0x22,0x32 on consecutive cycles from cycle 2; in_rdy stays 1.
- Backpressure: out_rdy=0, stream 0x01,0x02,0x03 -> first two accepted, in_rdy=0 on third, occupancy=2, out_msg=0x03 stable. Raise out_rdy -> 0x03,0x04,0x05 delivered in order.
- Wrap: in_msg=0xFE -> out_msg=0x00 without macro; out_msg=0xFF with REGINCR_PIPE_SAT_EN.
- Reset mid-flight: fill pipeline (occupancy=2, out_rdy=0), assert reset one cycle -> out_val=0, out_msg=0, occupancy=0, in_rdy=1; next message 0x40 -> 0x42 at normal latency.
- Params p_nbits=16, p_nstages=4, p_inc=3: in_msg=0x1234 -> out_msg=0x1240 after 4 cycles; random val/rdy stream matches a reference queue model.

Source files
------------

// File: rtl/regincr_pipe.sv
// regincr_pipe: an elastic val/rdy pipeline of p_nstages registers. Each
// register adds p_inc to the message as it passes through, so
// out_msg = in_msg + p_nstages*p_inc.
// Optional build macro REGINCR_PIPE_SAT_EN: when it is defined, each stage
// saturates at all-ones instead of wrapping.
module regincr_pipe #(
  parameter int p_nbits   = 8,
  parameter int p_nstages = 2,
  parameter int p_inc     = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_val,
  output logic                               in_rdy,
  input  logic [p_nbits-1:0]                 in_msg,
  output logic                               out_val,
  input  logic                               out_rdy,
  output logic [p_nbits-1:0]                 out_msg,
  output logic [$clog2(p_nstages+1)-1:0]     occupancy
);

  localparam int OCC_W = $clog2(p_nstages + 1);
  localparam logic [p_nbits-1:0] INC = p_nbits'(p_inc);

  // Per-stage add. The sum carries one extra bit so that an overflow can
  // be detected.
  function automatic logic [p_nbits-1:0] stage_add(input logic [p_nbits-1:0] src);
`ifdef REGINCR_PIPE_SAT_EN
    logic [p_nbits:0] sum;
    sum = {1'b0, src} + {1'b0, INC};
    stage_add = sum[p_nbits] ? {p_nbits{1'b1}} : sum[p_nbits-1:0];
`else
    stage_add = src + INC;
`endif
  endfunction

  logic [p_nstages-1:0] val_q;
  logic [p_nbits-1:0]   data_q [p_nstages];
  logic [OCC_W-1:0]     occ_q;

  logic [p_nstages-1:0] rdy;
  logic [p_nstages-1:0] src_val;
  logic [p_nbits-1:0]   src_msg [p_nstages];
  logic                 in_fire;
  logic                 out_fire;

  // Ready chain: a stage can load if it is empty or if its contents move on
  // this cycle. The chain runs combinationally from out_rdy back to stage 0.
  always_comb begin
    logic r;
    rdy = '0;
    r   = out_rdy;
    for (int i = p_nstages - 1; i >= 0; i--) begin
      r      = !val_q[i] || r;
      rdy[i] = r;
    end
  end

  // Source of each stage: stage 0 reads the input port, and later stages
  // read their predecessor.
  always_comb begin
    src_val    = '0;
    src_val[0] = in_val;
    src_msg[0] = in_msg;
    for (int i = 1; i < p_nstages; i++) begin
      src_val[i] = val_q[i-1];
      src_msg[i] = data_q[i-1];
    end
  end

  // Handshakes are gated during reset so nothing is accepted or delivered
  // while in-flight messages are being discarded.
  assign in_rdy    = rdy[0] && !reset;
  assign out_val   = val_q[p_nstages-1] && !reset;
  assign out_msg   = data_q[p_nstages-1];
  assign occupancy = occ_q;
  assign in_fire   = in_val && in_rdy;
  assign out_fire  = out_val && out_rdy;

  // Stage registers: load the incremented source when ready, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      val_q <= '0;
      for (int i = 0; i < p_nstages; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < p_nstages; i++) begin
        if (rdy[i]) begin
          val_q[i]  <= src_val[i];
          data_q[i] <= stage_add(src_msg[i]);
        end
      end
    end
  end

  // Occupancy counter: it counts up on an input fire and down on an output
  // fire. When both fire in the same cycle, the count stays the same.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0;
    end else if (in_fire && !out_fire) begin
      occ_q <= occ_q + 1'b1;
    end else if (!in_fire && out_fire) begin
      occ_q <= occ_q - 1'b1;
    end
  end

endmodule
